reindeer_mtimer: RTL and testbench

// - Machine timer: 64-bit free-running mtime and 64-bit mtimecmp, memory-mapped on a 32-bit register port.
// - Sits directly upstream of the CSR block and drives its timer_triggered input. The CSR edge-detects this input into MIP.MTIP.
// - timer_triggered is level: high while mtime >= mtimecmp.

---
 rtl/reindeer_mtimer_pkg.sv | 11 +
 rtl/reindeer_mtimer_prescaler.sv | 33 +++
 rtl/reindeer_mtimer.sv | 121 ++++++++++++
 tb/tb_reindeer_mtimer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/reindeer_mtimer_pkg.sv
// Shared register map and reset constants for the reindeer machine timer.
package reindeer_mtimer_pkg;

    localparam logic [1:0]  MTIMER_ADDR_MTIME_LO    = 2'd0;
    localparam logic [1:0]  MTIMER_ADDR_MTIME_HI    = 2'd1;
    localparam logic [1:0]  MTIMER_ADDR_MTIMECMP_LO = 2'd2;
    localparam logic [1:0]  MTIMER_ADDR_MTIMECMP_HI = 2'd3;

    localparam logic [63:0] MTIMER_CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/reindeer_mtimer_prescaler.sv
// Tick generator for mtime: one tick every PRESCALE_DIV clk cycles.
// Instantiated only when REINDEER_MTIMER_PRESCALER_EN is defined.
module reindeer_mtimer_prescaler #(
    parameter int PRESCALE_DIV = 100
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync_reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE_DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_terminal;

    // With PRESCALE_DIV=1 the count is pinned at 0, so every cycle ticks.
    assign w_terminal = (r_count == CNT_LAST);
    assign tick       = w_terminal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (sync_reset || clear || w_terminal) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/reindeer_mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp on a 32-bit register port, level trigger to the CSR block.
// Build option: REINDEER_MTIMER_PRESCALER_EN divides the mtime tick by PRESCALE_DIV.
module reindeer_mtimer
    import reindeer_mtimer_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int REG_ADDR_BITS = 2,
    parameter int PRESCALE_DIV  = 100
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sync_reset,
    input  logic                     reg_write_enable,
    input  logic                     reg_read_enable,
    input  logic [REG_ADDR_BITS-1:0] reg_addr,
    input  logic [XLEN-1:0]          reg_write_data,
    output logic                     reg_ack,
    output logic [XLEN-1:0]          reg_read_data,
    output logic                     timer_triggered
);

    localparam int CW = 2 * XLEN;

    logic [CW-1:0]   r_mtime;
    logic [CW-1:0]   r_mtimecmp;
    logic [XLEN-1:0] r_cmp_lo_shadow;
    logic [XLEN-1:0] r_mtime_hi_snap;
    logic [XLEN-1:0] r_read_data;
    logic            r_ack;
    logic            r_triggered;

    logic w_wr;
    logic w_rd;
    logic w_wr_mtime_lo;
    logic w_wr_mtime_hi;
    logic w_wr_cmp_lo;
    logic w_wr_cmp_hi;
    logic w_tick;

    // A simultaneous read and write strobe is treated as a write only.
    assign w_wr = reg_write_enable;
    assign w_rd = reg_read_enable & ~reg_write_enable;

    assign w_wr_mtime_lo = w_wr && (reg_addr == REG_ADDR_BITS'(MTIMER_ADDR_MTIME_LO));
    assign w_wr_mtime_hi = w_wr && (reg_addr == REG_ADDR_BITS'(MTIMER_ADDR_MTIME_HI));
    assign w_wr_cmp_lo   = w_wr && (reg_addr == REG_ADDR_BITS'(MTIMER_ADDR_MTIMECMP_LO));
    assign w_wr_cmp_hi   = w_wr && (reg_addr == REG_ADDR_BITS'(MTIMER_ADDR_MTIMECMP_HI));

`ifdef REINDEER_MTIMER_PRESCALER_EN
    reindeer_mtimer_prescaler #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) u_prescaler (
        .clk       (clk),
        .reset_n   (reset_n),
        .sync_reset(sync_reset),
        .clear     (w_wr_mtime_lo | w_wr_mtime_hi),
        .tick      (w_tick)
    );
`else
    // Undivided: tick every cycle; an illegal divider of 0 holds mtime instead.
    assign w_tick = (PRESCALE_DIV >= 1);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mtime         <= '0;
            r_mtimecmp      <= CW'(MTIMER_CMP_RESET);
            r_cmp_lo_shadow <= '0;
            r_mtime_hi_snap <= '0;
            r_read_data     <= '0;
            r_ack           <= 1'b0;
            r_triggered     <= 1'b0;
        end else if (sync_reset) begin
            r_mtime         <= '0;
            r_mtimecmp      <= CW'(MTIMER_CMP_RESET);
            r_cmp_lo_shadow <= '0;
            r_mtime_hi_snap <= '0;
            r_read_data     <= '0;
            r_ack           <= 1'b0;
            r_triggered     <= 1'b0;
        end else begin
            // A half write replaces only that half and swallows this cycle's tick.
            if (w_wr_mtime_lo) begin
                r_mtime[XLEN-1:0] <= reg_write_data;
            end else if (w_wr_mtime_hi) begin
                r_mtime[CW-1:XLEN] <= reg_write_data;
            end else if (w_tick) begin
                r_mtime <= r_mtime + CW'(1);
            end

            if (w_wr_cmp_lo) begin
                r_cmp_lo_shadow <= reg_write_data;
            end
            if (w_wr_cmp_hi) begin
                r_mtimecmp <= {reg_write_data, r_cmp_lo_shadow};
            end

            r_ack <= w_wr | w_rd;

            if (w_rd) begin
                case (reg_addr)
                    REG_ADDR_BITS'(MTIMER_ADDR_MTIME_LO): begin
                        r_read_data     <= r_mtime[XLEN-1:0];
                        r_mtime_hi_snap <= r_mtime[CW-1:XLEN];
                    end
                    REG_ADDR_BITS'(MTIMER_ADDR_MTIME_HI):    r_read_data <= r_mtime_hi_snap;
                    REG_ADDR_BITS'(MTIMER_ADDR_MTIMECMP_LO): r_read_data <= r_mtimecmp[XLEN-1:0];
                    REG_ADDR_BITS'(MTIMER_ADDR_MTIMECMP_HI): r_read_data <= r_mtimecmp[CW-1:XLEN];
                    default: ;
                endcase
            end

            r_triggered <= (r_mtime >= r_mtimecmp);
        end
    end

    assign reg_ack         = r_ack;
    assign reg_read_data   = r_read_data;
    assign timer_triggered = r_triggered;

endmodule

// File: tb/tb_reindeer_mtimer.sv
// Directed self-checking bench for reindeer_mtimer; covers the prescaler when REINDEER_MTIMER_PRESCALER_EN is defined.
module tb_reindeer_mtimer;
    import reindeer_mtimer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync_reset = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic        ack;
    logic [31:0] rdata;
    logic        trig;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reindeer_mtimer #(
        .XLEN(32),
        .REG_ADDR_BITS(2),
        .PRESCALE_DIV(4)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sync_reset      (sync_reset),
        .reg_write_enable(we),
        .reg_read_enable (re),
        .reg_addr        (addr),
        .reg_write_data  (wdata),
        .reg_ack         (ack),
        .reg_read_data   (rdata),
        .timer_triggered (trig)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller sits on a negedge; strobe is seen at the next posedge, result sampled at the following negedge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
        chk("wr_ack", {31'd0, ack}, 32'd1);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        re = 1'b1; addr = a;
        @(negedge clk);
        re = 1'b0;
        chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
        chk(tag, rdata, exp);
    endtask

    initial begin
        #2;
        chk("rst_trig", {31'd0, trig}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef REINDEER_MTIMER_PRESCALER_EN
        repeat (40) @(negedge clk);
        rd(MTIMER_ADDR_MTIME_LO, 32'd10, "presc_40cyc");
        repeat (2) @(negedge clk);
        chk("presc_pre_trig", {31'd0, trig}, 32'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("presc_arst_ack", {31'd0, ack}, 32'd0);
        chk("presc_arst_rdata", rdata, 32'd0);
        chk("presc_arst_trig", {31'd0, trig}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(MTIMER_ADDR_MTIME_LO, 32'd0, "presc_after_rst");
`else
        // Idle after reset
        repeat (5) @(negedge clk);
        chk("idle_trig", {31'd0, trig}, 32'd0);
        rd(MTIMER_ADDR_MTIME_LO, 32'd5, "idle_mtime_lo");
        rd(MTIMER_ADDR_MTIMECMP_HI, 32'hFFFF_FFFF, "idle_cmp_hi");
        @(negedge clk);
        chk("idle_ack_low", {31'd0, ack}, 32'd0);
        chk("idle_rdata_hold", rdata, 32'hFFFF_FFFF);

        // Carry across the 32-bit boundary and the LO/HI pair
        wr(MTIMER_ADDR_MTIME_HI, 32'd0);
        wr(MTIMER_ADDR_MTIME_LO, 32'hFFFF_FFFE);
        repeat (3) @(negedge clk);
        rd(MTIMER_ADDR_MTIME_LO, 32'h0000_0001, "carry_lo");
        repeat (3) @(negedge clk);
        rd(MTIMER_ADDR_MTIME_HI, 32'h0000_0001, "carry_hi");

        // Snapshot taken before the carry must survive it
        wr(MTIMER_ADDR_MTIME_HI, 32'd0);
        wr(MTIMER_ADDR_MTIME_LO, 32'hFFFF_FFFD);
        @(negedge clk);
        rd(MTIMER_ADDR_MTIME_LO, 32'hFFFF_FFFE, "snap_lo");
        repeat (3) @(negedge clk);
        rd(MTIMER_ADDR_MTIME_HI, 32'h0000_0000, "snap_hi");

        // Compare rise at mtime == 0x20 and drop on recommit
        wr(MTIMER_ADDR_MTIME_HI, 32'd0);
        wr(MTIMER_ADDR_MTIMECMP_LO, 32'h20);
        wr(MTIMER_ADDR_MTIMECMP_HI, 32'd0);
        wr(MTIMER_ADDR_MTIME_LO, 32'd0);
        repeat (31) @(negedge clk);
        chk("cmp_mtime1f", {31'd0, trig}, 32'd0);
        @(negedge clk);
        chk("cmp_mtime20", {31'd0, trig}, 32'd0);
        @(negedge clk);
        chk("cmp_rise", {31'd0, trig}, 32'd1);
        wr(MTIMER_ADDR_MTIMECMP_HI, 32'hFFFF_FFFF);
        chk("cmp_commit_edge", {31'd0, trig}, 32'd1);
        @(negedge clk);
        chk("cmp_drop", {31'd0, trig}, 32'd0);

        // Half-written mtimecmp must not take effect
        wr(MTIMER_ADDR_MTIMECMP_LO, 32'hFFFF_FFFF);
        wr(MTIMER_ADDR_MTIMECMP_HI, 32'hFFFF_FFFF);
        wr(MTIMER_ADDR_MTIME_HI, 32'd1);
        wr(MTIMER_ADDR_MTIME_LO, 32'd0);
        wr(MTIMER_ADDR_MTIMECMP_LO, 32'd0);
        repeat (3) @(negedge clk);
        chk("atomic_hold", {31'd0, trig}, 32'd0);
        rd(MTIMER_ADDR_MTIMECMP_LO, 32'hFFFF_FFFF, "atomic_cmp_lo_live");
        chk("atomic_hold2", {31'd0, trig}, 32'd0);
        wr(MTIMER_ADDR_MTIMECMP_HI, 32'd1);
        chk("atomic_commit_edge", {31'd0, trig}, 32'd0);
        @(negedge clk);
        chk("atomic_rise", {31'd0, trig}, 32'd1);
        rd(MTIMER_ADDR_MTIMECMP_LO, 32'd0, "atomic_cmp_lo");
        rd(MTIMER_ADDR_MTIMECMP_HI, 32'd1, "atomic_cmp_hi");

        // Write on a tick cycle at all ones: write wins, no wrap
        wr(MTIMER_ADDR_MTIME_HI, 32'hFFFF_FFFF);
        wr(MTIMER_ADDR_MTIME_LO, 32'hFFFF_FFFE);
        @(negedge clk);
        wr(MTIMER_ADDR_MTIME_LO, 32'd5);
        rd(MTIMER_ADDR_MTIME_LO, 32'd5, "simul_lo");
        rd(MTIMER_ADDR_MTIME_HI, 32'hFFFF_FFFF, "simul_hi");

        // 64-bit wrap with cmp = 1
        wr(MTIMER_ADDR_MTIMECMP_LO, 32'd1);
        wr(MTIMER_ADDR_MTIMECMP_HI, 32'd0);
        wr(MTIMER_ADDR_MTIME_HI, 32'hFFFF_FFFF);
        wr(MTIMER_ADDR_MTIME_LO, 32'hFFFF_FFFD);
        repeat (3) @(negedge clk);
        chk("wrap_all_ones", {31'd0, trig}, 32'd1);
        @(negedge clk);
        chk("wrap_zero_fall", {31'd0, trig}, 32'd0);
        @(negedge clk);
        chk("wrap_one_rise", {31'd0, trig}, 32'd1);
        rd(MTIMER_ADDR_MTIME_LO, 32'd2, "wrap_lo");

        // Read and write together: one ack, read ignored
        we = 1'b1; re = 1'b1; addr = MTIMER_ADDR_MTIMECMP_LO; wdata = 32'h77;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        chk("rw_ack", {31'd0, ack}, 32'd1);
        chk("rw_rdata_hold", rdata, 32'd2);
        @(negedge clk);
        chk("rw_single_ack", {31'd0, ack}, 32'd0);

        // Back-to-back reads
        re = 1'b1; addr = MTIMER_ADDR_MTIMECMP_LO;
        @(negedge clk);
        chk("b2b_ack0", {31'd0, ack}, 32'd1);
        chk("b2b_cmp_lo", rdata, 32'd1);
        addr = MTIMER_ADDR_MTIMECMP_HI;
        @(negedge clk);
        re = 1'b0;
        chk("b2b_ack1", {31'd0, ack}, 32'd1);
        chk("b2b_cmp_hi", rdata, 32'd0);
        @(negedge clk);
        chk("b2b_ack_end", {31'd0, ack}, 32'd0);

        // Synchronous reset clears everything including the lo shadow
        sync_reset = 1'b1;
        @(negedge clk);
        sync_reset = 1'b0;
        chk("srst_trig", {31'd0, trig}, 32'd0);
        chk("srst_ack", {31'd0, ack}, 32'd0);
        chk("srst_rdata", rdata, 32'd0);
        rd(MTIMER_ADDR_MTIME_LO, 32'd0, "srst_mtime_lo");
        rd(MTIMER_ADDR_MTIMECMP_HI, 32'hFFFF_FFFF, "srst_cmp_hi");
        wr(MTIMER_ADDR_MTIMECMP_HI, 32'd0);
        rd(MTIMER_ADDR_MTIMECMP_LO, 32'd0, "srst_shadow");

        // Async reset with an ack in flight
        @(negedge clk);
        chk("arst_pre_trig", {31'd0, trig}, 32'd1);
        re = 1'b1; addr = MTIMER_ADDR_MTIME_LO;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        re = 1'b0;
        #1;
        chk("arst_ack", {31'd0, ack}, 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        chk("arst_trig", {31'd0, trig}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(MTIMER_ADDR_MTIME_LO, 32'd0, "arst_mtime_lo");
        rd(MTIMER_ADDR_MTIMECMP_HI, 32'hFFFF_FFFF, "arst_cmp_hi");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
